// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   OP_*        : shift mode encodings carried alongside each operand
//   MAX_W       : widest datapath the shared level function supports
//   shift_level : one log2 level of shifting (shift by s) for a width-bit operand,
//                 operand and result right-aligned in a MAX_W container
package shifter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam int MAX_W   = 64;
  localparam int MAX_SHW = 6;

  // Bits at or above `width` in the result are always zero; `s` is a constant
  // per stage, so each call collapses to plain wiring plus a per-bit mux.
  function automatic logic [MAX_W-1:0] shift_level(
    input logic [MAX_W-1:0] data,
    input logic [1:0]       op,
    input int unsigned      s,
    input int unsigned      width
  );
    logic [MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        case (op)
          OP_SLL: begin
            res[MAX_SHW'(i)] = (i >= s) ? data[MAX_SHW'(i - s)] : 1'b0;
          end
          OP_SRL: begin
            res[MAX_SHW'(i)] = (i + s < width) ? data[MAX_SHW'(i + s)] : 1'b0;
          end
          OP_SRA: begin
            // Earlier levels keep the MSB intact, so the stage input MSB is the
            // original sign.
            res[MAX_SHW'(i)] = (i + s < width) ? data[MAX_SHW'(i + s)]
                                               : data[MAX_SHW'(width - 1)];
          end
          default: begin
            res[MAX_SHW'(i)] = data[MAX_SHW'((i + s) % width)];
          end
        endcase
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered shift level of the pipelined barrel shifter.
// The stage shifts its input by 2^LEVEL when in_amt[LEVEL] is set and registers
// the result together with the amount, op and valid bit for the next level.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : upstream has an operand for this level
//   in_data/amt/op : operand, full shift amount, shift mode
//   stage_ready  : this stage may load this cycle (empty, or its contents leave)
//   out_valid    : registered operand present
//   out_data/amt/op : registered result, amount and mode for the next level
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEVEL = 0,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic             stage_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output logic [1:0]       out_op
);

  localparam int unsigned LEVEL_STEP = 32'd1 << LEVEL;
  localparam int unsigned WIDTH_U    = WIDTH;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [SHW-1:0]   amt_d, amt_q;
  logic [1:0]       op_d, op_q;
  logic [WIDTH-1:0] level_out;

  always_comb begin
    level_out = in_data;
    if (in_amt[LEVEL]) begin
      level_out = WIDTH'(shift_level(MAX_W'(in_data), in_op, LEVEL_STEP, WIDTH_U));
    end
  end

  // When the stage cannot load it keeps everything, so a stalled operand is
  // never corrupted and no bubble appears when the stall clears.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    if (stage_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = level_out;
        amt_d  = in_amt;
        op_d   = in_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;
  assign out_op    = op_q;

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: one log2 shift level per stage, SHW stages, the last
// stage doubling as the output register. Valid/ready on both sides, 1 op/cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid, in_ready, in_data, in_amt, in_op : operand side
//                (op: 00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   out_valid, out_ready, out_data             : result side
module pipe_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Index k is the input of stage k; index SHW is the output register's content.
  logic             st_valid [SHW+1];
  logic [WIDTH-1:0] st_data  [SHW+1];
  logic [SHW-1:0]   st_amt   [SHW+1];
  logic [1:0]       st_op    [SHW+1];
  logic [SHW:0]     ready_chain;
  logic             unused_tail;

  assign st_valid[0] = in_valid;
  assign st_data[0]  = in_data;
  assign st_amt[0]   = in_amt;
  assign st_op[0]    = in_op;

  // Stage k may load when it is empty or when the stage after it can take its
  // contents this cycle. Evaluated from the output backwards in one block.
  always_comb begin
    ready_chain      = '0;
    ready_chain[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      ready_chain[k] = !st_valid[k+1] || ready_chain[k+1];
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .LEVEL (k),
      .SHW   (SHW)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (st_valid[k]),
      .in_data     (st_data[k]),
      .in_amt      (st_amt[k]),
      .in_op       (st_op[k]),
      .stage_ready (ready_chain[k]),
      .out_valid   (st_valid[k+1]),
      .out_data    (st_data[k+1]),
      .out_amt     (st_amt[k+1]),
      .out_op      (st_op[k+1])
    );
  end

  assign in_ready  = ready_chain[0];
  assign out_valid = st_valid[SHW];
  assign out_data  = st_data[SHW];

  // Amount and mode are fully consumed by the last level.
  assign unused_tail = ^{st_amt[SHW], st_op[SHW]};

  // A presented result may not be withdrawn or changed before it is taken.
  property p_out_hold;
    @(posedge clk) disable iff (!rst_n)
      out_valid && !out_ready |=> out_valid && $stable(out_data);
  endproperty
  a_out_hold: assert property (p_out_hold);

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
module tb_pipe_barrel_shifter;
  import shifter_pkg::*;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_amt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  bit          sweep_go = 0;
  bit          prod_done = 0;
  int          n_out = 0;
  longint unsigned q[$];

  typedef struct {
    logic [7:0] d;
    logic [1:0] op;
    logic [2:0] a;
    logic [7:0] e;
  } vec_t;

  vec_t t2 [6] = '{
    '{8'hD6, OP_SLL, 3'd3, 8'hB0},
    '{8'hD6, OP_SRL, 3'd3, 8'h1A},
    '{8'hD6, OP_SRA, 3'd3, 8'hFA},
    '{8'h56, OP_SRA, 3'd3, 8'h0A},
    '{8'h80, OP_SRA, 3'd7, 8'hFF},
    '{8'h80, OP_SRL, 3'd7, 8'h01}
  };

  pipe_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Whole-amount shift of a w-bit value, straight from the mode definitions.
  function automatic longint unsigned ref_shift(input longint unsigned d, input int unsigned a,
                                                input int unsigned op, input int unsigned w);
    longint unsigned m, r, x;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = d & m;
    case (op)
      0: r = (x << a) & m;
      1: r = x >> a;
      2: begin
        r = x >> a;
        if (((x >> (w - 1)) & 64'd1) != 0) r = r | (m & ~(m >> a));
      end
      default: r = ((x >> a) | (x << (w - a))) & m;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = o;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit empty = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 60 && !empty; t++) begin
      @(negedge clk);
      empty = (q.size() == 0) && !out_valid;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Model scoreboard: every cycle the result side is live it must present the
  // oldest outstanding result, and hold it while stalled.
  initial begin
    bit              hold = 0;
    logic [W-1:0]    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        hold = 0;
        continue;
      end
      if (hold) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(hold_data));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          chk("model_data", 64'(out_data), q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      if (in_valid && in_ready) q.push_back(ref_shift(64'(in_data), in_amt, in_op, W));
    end
  end

  // Other widths: every amount x mode back to back, latency must be exactly SHW.
  for (genvar g = 0; g < 3; g++) begin : sweep
    localparam int SW = (g == 0) ? 2 : (g == 1) ? 16 : 32;
    localparam int SS = $clog2(SW);
    logic          iv;
    logic          ir;
    logic [SW-1:0] id;
    logic [SS-1:0] ia;
    logic [1:0]    io;
    logic          ov;
    logic [SW-1:0] od;
    bit            done = 0;
    longint unsigned eq[$];
    int unsigned     acq[$];

    pipe_barrel_shifter #(.WIDTH(SW)) dut_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .in_amt    (ia),
      .in_op     (io),
      .out_valid (ov),
      .out_ready (1'b1),
      .out_data  (od)
    );

    initial begin
      iv = 1'b0;
      id = '0;
      ia = '0;
      io = 2'b00;
      wait (sweep_go);
      @(posedge clk);
      #1;
      for (int a = 0; a < SW; a++) begin
        for (int o = 0; o < 4; o++) begin
          iv = 1'b1;
          id = SW'($urandom);
          ia = SS'(a);
          io = 2'(o);
          @(posedge clk);
          #1;
        end
      end
      iv = 1'b0;
      for (int t = 0; t < 50 && eq.size() != 0; t++) @(posedge clk);
      chk($sformatf("sw%0d_drain", SW), 64'(eq.size()), 64'd0);
      done = 1;
    end

    initial forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (ov) begin
        if (eq.size() == 0) begin
          chk($sformatf("sw%0d_spurious", SW), 64'(ov), 64'd0);
        end else begin
          chk($sformatf("sw%0d_data", SW), 64'(od), eq[0]);
          chk($sformatf("sw%0d_latency", SW), 64'(cyc - acq[0]), 64'(SS));
          void'(eq.pop_front());
          void'(acq.pop_front());
        end
      end
      if (iv) begin
        chk($sformatf("sw%0d_in_ready", SW), 64'(ir), 64'd1);
        if (ir) begin
          eq.push_back(ref_shift(64'(id), ia, io, SW));
          acq.push_back(cyc);
        end
      end
    end
  end

  initial begin
    logic [7:0] t1_exp [4];
    logic [7:0] t3_d [6];
    int         n0;
    int unsigned c0;
    bit         got;

    t1_exp = '{8'hD6, 8'h6B, 8'hDA, 8'hAD};
    t3_d   = '{8'h13, 8'hA5, 8'hFF, 8'h01, 8'h80, 8'h7E};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = OP_SLL;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // 1: ROR of D6 by 0/1/3/7 back to back
    send(8'hD6, 3'd0, OP_ROR);
    send(8'hD6, 3'd1, OP_ROR);
    in_valid = 1'b1;
    in_amt   = 3'd3;
    @(negedge clk);
    chk("t1_not_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_amt = 3'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_data", 64'(out_data), 64'(t1_exp[i]));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    wait_drain();

    // 2: single ops with hand-computed results
    for (int i = 0; i < 6; i++) begin
      send(t2[i].d, t2[i].a, t2[i].op);
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = out_valid;
      end
      chk("t2_valid", 64'(got), 64'd1);
      chk("t2_data", 64'(out_data), 64'(t2[i].e));
      @(posedge clk);
      #1;
    end
    wait_drain();

    // 3: stream 6 ops, consumer stalls in cycles 4-8
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(t3_d[i], 3'(i + 1), 2'(i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("t3_in_ready_low", 64'(in_ready), 64'd0);
        chk("t3_held", 64'(q.size()), 64'd3);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("t3_count", 64'(n_out - n0), 64'd6);

    // 4a: full pipe with simultaneous drain takes one op per cycle
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(8'(8'h3C + i * 17), 3'(i), 2'(i));
    chk("t4_no_bubble", 64'(cyc - c0), 64'd8);
    wait_drain();

    // 4b: random valid/ready for 10k ops
    n0 = n_out;
    prod_done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom), 3'($urandom), 2'($urandom));
        end
        prod_done = 1;
      end
      begin
        while (!prod_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    wait_drain();
    chk("t4_count", 64'(n_out - n0), 64'd10000);

    // 5: asynchronous reset with three ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'hF0 + 8'(i), 3'd2, OP_SRA);
    @(negedge clk);
    chk("t5_full", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_data", 64'(out_data), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // 6: width sweep
    sweep_go = 1;
    got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(posedge clk);
      got = sweep[0].done && sweep[1].done && sweep[2].done;
    end
    chk("sweep_done", 64'(got), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
